// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall and forwarding-select generation for the five-stage pipeline with mult/div unit
module hazard_fwd_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wreg,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_kind,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [3:0] fwd_rs_d,
    output logic [3:0] fwd_rt_d,
    output logic [3:0] fwd_rs_e,
    output logic [3:0] fwd_rt_e,
    output logic [3:0] fwd_rt_m,
    output logic       md_busy
);
    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_PC8  = 2'd2;
    localparam logic [1:0] K_HILO = 2'd3;
    localparam logic [4:0] L_MULT = 5'(MULT_CYC);
    localparam logic [4:0] L_DIV  = 5'(DIV_CYC);

    logic       r_e_valid, r_e_md_start, r_e_md_div;
    logic [4:0] r_e_rs, r_e_rt, r_e_wreg;
    logic [1:0] r_e_tnew, r_e_kind;
    logic       r_m_valid;
    logic [4:0] r_m_rt, r_m_wreg;
    logic [1:0] r_m_tnew, r_m_kind;
    logic       r_w_valid;
    logic [4:0] r_w_wreg;
    logic [4:0] r_cnt;

    logic       w_e_blk, w_e_pc8, w_md_busy;
    logic [3:0] w_m_code;
    logic       w_e_hit_rs_d, w_e_hit_rt_d, w_m_hit_rs_d, w_m_hit_rt_d, w_w_hit_rs_d, w_w_hit_rt_d;
    logic       w_m_hit_rs_e, w_m_hit_rt_e, w_w_hit_rs_e, w_w_hit_rt_e, w_w_hit_rt_m;

    function automatic logic f_hit(input logic v, input logic [4:0] w, input logic [4:0] r);
        return v && (w != 5'd0) && (w == r);
    endfunction

    // nearest stage wins; an unready match in a nearer stage suppresses older values
    function automatic logic [3:0] f_sel(input logic e_hit, input logic e_blk, input logic e_pc8,
                                         input logic m_hit, input logic [3:0] m_code, input logic w_hit);
        return (e_hit && e_blk) ? 4'd0 : (e_hit && e_pc8) ? 4'd1 : m_hit ? m_code : w_hit ? 4'd5 : 4'd0;
    endfunction

    function automatic logic f_hz(input logic e_hit, input logic m_hit, input logic [1:0] e_tnew,
                                  input logic [1:0] m_tnew, input logic [1:0] tuse);
        return (tuse != 2'd3) && ((e_hit && (e_tnew > tuse)) || (m_hit && (m_tnew > tuse)));
    endfunction

    assign w_e_blk      = r_e_tnew != 2'd0;
    assign w_e_pc8      = r_e_kind == K_PC8;
    assign w_m_code     = (r_m_tnew != 2'd0) ? 4'd0 :
                          (r_m_kind == K_ALU) ? 4'd2 : (r_m_kind == K_PC8) ? 4'd3 :
                          (r_m_kind == K_HILO) ? 4'd4 : 4'd0;
    assign w_md_busy    = r_cnt != 5'd0;
    assign w_e_hit_rs_d = f_hit(r_e_valid, r_e_wreg, d_rs);
    assign w_e_hit_rt_d = f_hit(r_e_valid, r_e_wreg, d_rt);
    assign w_m_hit_rs_d = f_hit(r_m_valid, r_m_wreg, d_rs);
    assign w_m_hit_rt_d = f_hit(r_m_valid, r_m_wreg, d_rt);
    assign w_w_hit_rs_d = f_hit(r_w_valid, r_w_wreg, d_rs);
    assign w_w_hit_rt_d = f_hit(r_w_valid, r_w_wreg, d_rt);
    assign w_m_hit_rs_e = f_hit(r_m_valid, r_m_wreg, r_e_rs);
    assign w_m_hit_rt_e = f_hit(r_m_valid, r_m_wreg, r_e_rt);
    assign w_w_hit_rs_e = f_hit(r_w_valid, r_w_wreg, r_e_rs);
    assign w_w_hit_rt_e = f_hit(r_w_valid, r_w_wreg, r_e_rt);
    assign w_w_hit_rt_m = f_hit(r_w_valid, r_w_wreg, r_m_rt);

    // combinational stall and forwarding selects from pre-edge stage state
    always_comb begin
        md_busy  = w_md_busy;
        fwd_rs_d = f_sel(w_e_hit_rs_d, w_e_blk, w_e_pc8, w_m_hit_rs_d, w_m_code, w_w_hit_rs_d);
        fwd_rt_d = f_sel(w_e_hit_rt_d, w_e_blk, w_e_pc8, w_m_hit_rt_d, w_m_code, w_w_hit_rt_d);
        fwd_rs_e = f_sel(1'b0, 1'b0, 1'b0, w_m_hit_rs_e, w_m_code, w_w_hit_rs_e);
        fwd_rt_e = f_sel(1'b0, 1'b0, 1'b0, w_m_hit_rt_e, w_m_code, w_w_hit_rt_e);
        fwd_rt_m = w_w_hit_rt_m ? 4'd5 : 4'd0;
        stall    = d_valid && (f_hz(w_e_hit_rs_d, w_m_hit_rs_d, r_e_tnew, r_m_tnew, d_tuse_rs) ||
                               f_hz(w_e_hit_rt_d, w_m_hit_rt_d, r_e_tnew, r_m_tnew, d_tuse_rt) ||
                               (d_md_use && (w_md_busy || (r_e_valid && r_e_md_start))));
    end

    // E record: capture D, or take a bubble while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stall) begin
            r_e_valid    <= 1'b0;
            r_e_rs       <= 5'd0;
            r_e_rt       <= 5'd0;
            r_e_wreg     <= 5'd0;
            r_e_tnew     <= 2'd0;
            r_e_kind     <= 2'd0;
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
        end else begin
            r_e_valid    <= d_valid;
            r_e_rs       <= d_rs;
            r_e_rt       <= d_rt;
            r_e_wreg     <= d_wreg;
            r_e_tnew     <= d_tnew;
            r_e_kind     <= d_kind;
            r_e_md_start <= d_md_start;
            r_e_md_div   <= d_md_div;
        end
    end

    // M and W records always advance; tnew counts down toward readiness
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_valid <= 1'b0;
            r_m_rt    <= 5'd0;
            r_m_wreg  <= 5'd0;
            r_m_tnew  <= 2'd0;
            r_m_kind  <= 2'd0;
            r_w_valid <= 1'b0;
            r_w_wreg  <= 5'd0;
        end else begin
            r_m_valid <= r_e_valid;
            r_m_rt    <= r_e_rt;
            r_m_wreg  <= r_e_wreg;
            r_m_tnew  <= (r_e_tnew != 2'd0) ? r_e_tnew - 2'd1 : 2'd0;
            r_m_kind  <= r_e_kind;
            r_w_valid <= r_m_valid;
            r_w_wreg  <= r_m_wreg;
        end
    end

    // mult/div busy counter, loaded as the starting instruction leaves E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= 5'd0;
        else r_cnt <= (r_e_valid && r_e_md_start) ? (r_e_md_div ? L_DIV : L_MULT) :
                      (r_cnt != 5'd0) ? r_cnt - 5'd1 : 5'd0;
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed and randomized checks of hazard_fwd_ctrl against an age-based pipeline model
module tb_hazard_fwd_ctrl;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_valid, d_md_start, d_md_div, d_md_use;
    logic [4:0] d_rs, d_rt, d_wreg;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_kind;
    logic       stall, md_busy;
    logic [3:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
    int checks = 0;
    int errors = 0;

    hazard_fwd_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wreg(d_wreg), .d_tnew(d_tnew),
        .d_kind(d_kind), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // model: m[0]=E, m[1]=M, m[2]=W; tnew kept as issued, readiness derived from stage age
    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt, wr;
        logic [1:0] tn, kd;
        logic       md, dv;
    } rec_t;
    rec_t m[3];
    int cyc = 0;
    int md_end = 0;

    function automatic int eff(int s);
        int t = int'(m[s].tn);
        if (s == 2) return 0;
        return (t > s) ? t - s : 0;
    endfunction

    function automatic bit hit(int s, logic [4:0] r);
        return m[s].v && m[s].wr != 5'd0 && m[s].wr == r;
    endfunction

    function automatic bit busy();
        return cyc < md_end;
    endfunction

    function automatic int exp_fwd(int c, logic [4:0] r);
        for (int s = c + 1; s < 3; s++) begin
            if (!hit(s, r)) continue;
            if (eff(s) != 0) return 0;
            if (s == 0) begin
                if (m[0].kd == 2'd2) return 1;
                continue;
            end
            if (s == 1) return (m[1].kd == 2'd0) ? 2 : (m[1].kd == 2'd2) ? 3 : (m[1].kd == 2'd3) ? 4 : 0;
            return 5;
        end
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit h = 1'b0;
        if (!d_valid) return 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (d_tuse_rs != 2'd3 && hit(s, d_rs) && eff(s) > int'(d_tuse_rs)) h = 1'b1;
            if (d_tuse_rt != 2'd3 && hit(s, d_rt) && eff(s) > int'(d_tuse_rt)) h = 1'b1;
        end
        if (d_md_use && (busy() || (m[0].v && m[0].md))) h = 1'b1;
        return h;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 3; s++) m[s] <= '0;
            md_end <= 0;
        end else begin
            if (m[0].v && m[0].md) md_end <= cyc + 1 + (m[0].dv ? DIV_CYC : MULT_CYC);
            cyc <= cyc + 1;
            m[2] <= m[1];
            m[1] <= m[0];
            if (exp_stall()) m[0] <= '0;
            else m[0] <= '{d_valid, d_rs, d_rt, d_wreg, d_tnew, d_kind, d_md_start, d_md_div};
        end
    end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", int'(stall), int'(exp_stall()));
        chk("md_busy", int'(md_busy), int'(busy()));
        chk("fwd_rs_d", int'(fwd_rs_d), exp_fwd(-1, d_rs));
        chk("fwd_rt_d", int'(fwd_rt_d), exp_fwd(-1, d_rt));
        chk("fwd_rs_e", int'(fwd_rs_e), exp_fwd(0, m[0].rs));
        chk("fwd_rt_e", int'(fwd_rt_e), exp_fwd(0, m[0].rt));
        chk("fwd_rt_m", int'(fwd_rt_m), exp_fwd(1, m[1].rt));
    end

    task automatic setd(input bit v, input int rs, input int rt, input int tr, input int tt,
                        input int wr, input int tn, input int kd,
                        input bit ms = 1'b0, input bit dv = 1'b0, input bit mu = 1'b0);
        d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tr); d_tuse_rt = 2'(tt);
        d_wreg = 5'(wr); d_tnew = 2'(tn); d_kind = 2'(kd);
        d_md_start = ms; d_md_div = dv; d_md_use = mu;
    endtask

    task automatic nop();
        setd(1'b0, 0, 0, 3, 3, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) step();
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_stall"}, int'(stall), 0);
        chk({n, "_md_busy"}, int'(md_busy), 0);
        chk({n, "_fwd_rs_d"}, int'(fwd_rs_d), 0);
        chk({n, "_fwd_rt_d"}, int'(fwd_rt_d), 0);
        chk({n, "_fwd_rs_e"}, int'(fwd_rs_e), 0);
        chk({n, "_fwd_rt_e"}, int'(fwd_rt_e), 0);
        chk({n, "_fwd_rt_m"}, int'(fwd_rt_m), 0);
    endtask

    initial begin
        int n;
        nop();
        #1 reset = 1'b0;
        #1 chk_zero("por");
        step();
        reset = 1'b1;
        // reset in the middle of a divide, with a W-stage producer visible to D
        setd(1'b1, 1, 2, 1, 1, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        step();
        nop();
        step();
        setd(1'b1, 1, 2, 1, 1, 4, 1, 0);
        step();
        nop();
        step();
        step();
        setd(1'b1, 4, 0, 0, 3, 9, 1, 3, 1'b0, 1'b0, 1'b1);
        #1;
        chk("middiv_busy", int'(md_busy), 1);
        chk("middiv_stall", int'(stall), 1);
        chk("middiv_fwd_rs_d", int'(fwd_rs_d), 5);
        #1 reset = 1'b0;
        #1 chk_zero("async_rst");
        step();
        nop();
        reset = 1'b1;
        #1 chk_zero("rst_rel");
        step();
        chk_zero("rst_rel2");
        // load-use: one stall cycle, then W forward into E
        setd(1'b1, 1, 3, 1, 3, 8, 2, 1);
        step();
        setd(1'b1, 8, 9, 1, 1, 10, 1, 0);
        #1 chk("lu_stall1", int'(stall), 1);
        step();
        #1 chk("lu_stall2", int'(stall), 0);
        step();
        nop();
        #1;
        chk("lu_fwd_rs_e", int'(fwd_rs_e), 5);
        chk("lu_fwd_rt_e", int'(fwd_rt_e), 0);
        flush();
        // ALU chain through M
        setd(1'b1, 1, 2, 1, 1, 3, 1, 0);
        step();
        setd(1'b1, 6, 3, 1, 1, 7, 1, 0);
        #1 chk("alu_stall", int'(stall), 0);
        step();
        nop();
        #1 chk("alu_fwd_rt_e", int'(fwd_rt_e), 2);
        flush();
        setd(1'b1, 1, 2, 1, 1, 0, 1, 0);
        step();
        setd(1'b1, 6, 0, 1, 1, 7, 1, 0);
        step();
        nop();
        #1 chk("r0_fwd_rt_e", int'(fwd_rt_e), 0);
        flush();
        // branch operand from jal in E, then from an ALU result after one stall
        setd(1'b1, 0, 0, 3, 3, 31, 0, 2);
        step();
        setd(1'b1, 31, 0, 0, 0, 0, 0, 0);
        #1;
        chk("jal_fwd_rs_d", int'(fwd_rs_d), 1);
        chk("jal_stall", int'(stall), 0);
        flush();
        setd(1'b1, 1, 2, 1, 1, 31, 1, 0);
        step();
        setd(1'b1, 31, 0, 0, 0, 0, 0, 0);
        #1 chk("br_stall1", int'(stall), 1);
        step();
        #1;
        chk("br_stall2", int'(stall), 0);
        chk("br_fwd_rs_d", int'(fwd_rs_d), 2);
        flush();
        // divide followed by mfhi
        setd(1'b1, 1, 2, 1, 1, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        step();
        setd(1'b1, 0, 0, 3, 3, 2, 1, 3, 1'b0, 1'b0, 1'b1);
        #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            step();
            #1;
        end
        chk("div_stall_cycles", n, DIV_CYC + 1);
        chk("div_busy_end", int'(md_busy), 0);
        chk("div_stall_end", int'(stall), 0);
        flush();
        // store data from W into M
        setd(1'b1, 1, 3, 1, 3, 5, 2, 1);
        step();
        setd(1'b1, 1, 5, 1, 2, 0, 0, 0);
        #1 chk("sw_stall", int'(stall), 0);
        step();
        nop();
        step();
        #1 chk("sw_fwd_rt_m", int'(fwd_rt_m), 5);
        flush();
        setd(1'b1, 1, 3, 1, 3, 6, 2, 1);
        step();
        setd(1'b1, 1, 5, 1, 2, 0, 0, 0);
        step();
        nop();
        step();
        #1 chk("sw6_fwd_rt_m", int'(fwd_rt_m), 0);
        flush();
        // randomized traffic over a small register set to provoke frequent matches
        for (int i = 0; i < 3000; i++) begin
            bit mu;
            mu = ($urandom_range(0, 3) == 0);
            setd($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 mu && ($urandom_range(0, 2) == 0), 1'($urandom), mu);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end
        nop();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
